// File: rtl/softmax_sched.sv
// softmax_sched
// Round-robin scheduler that time-shares one softmax_approx engine among
// NUM_REQ requesters. One requester is granted at a time. gnt_idx steers that
// requester's data to and from the engine. The engine is started with a
// one-cycle sm_start pulse, and the scheduler waits for sm_done. The result is
// a one-hot rsp_done pulse back to the owner. A watchdog bounds the wait: when
// it expires, the engine is flushed through sm_rst and the owner gets a
// one-hot rsp_error pulse.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   req            level request per requester
//   gnt_idx        index of the requester owning the engine
//   busy           high whenever the scheduler is not idle
//   sm_start       one-cycle engine start pulse
//   sm_done        engine done pulse (only honoured while waiting)
//   sm_rst         engine flush request, high for both flush cycles
//   rsp_done       one-hot completion pulse at gnt_idx
//   rsp_error      one-hot timeout pulse at gnt_idx
//   job_count      completed jobs, wraps
//   timeout_count  timeouts, saturates at 255
module softmax_sched #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       busy,
   output logic                       sm_start,
   input  logic                       sm_done,
   output logic                       sm_rst,
   output logic [NUM_REQ-1:0]         rsp_done,
   output logic [NUM_REQ-1:0]         rsp_error,
   output logic [CNT_W-1:0]           job_count,
   output logic [7:0]                 timeout_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LAUNCH  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_RESPOND = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             flush2_q, flush2_d;
   logic [CNT_W-1:0] job_q, job_d;
   logic [7:0]       tmo_q, tmo_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand_idx;
   logic [NUM_REQ-1:0] gnt_onehot;

   // Circular priority search starting at the round-robin pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      wd_d     = wd_q;
      flush2_d = 1'b0;
      job_d    = job_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               gnt_d   = pick_idx;
               ptr_d   = IDX_W'((int'(pick_idx) + 1) % NUM_REQ);
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done on the final watchdog cycle still counts as success.
            if (sm_done) begin
               state_d = S_RESPOND;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               state_d = S_FLUSH;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_RESPOND: begin
            job_d   = job_q + 1'b1;
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            // flush2_q tells the first flush cycle from the second one.
            if (!flush2_q) begin
               flush2_d = 1'b1;
               if (tmo_q != 8'hFF) begin
                  tmo_d = tmo_q + 8'd1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         ptr_q    <= '0;
         wd_q     <= '0;
         flush2_q <= 1'b0;
         job_q    <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         wd_q     <= wd_d;
         flush2_q <= flush2_d;
         job_q    <= job_d;
         tmo_q    <= tmo_d;
      end
   end

   assign gnt_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
   assign gnt_idx       = gnt_q;
   assign busy          = (state_q != S_IDLE);
   assign sm_start      = (state_q == S_LAUNCH);
   assign sm_rst        = (state_q == S_FLUSH);
   assign rsp_done      = (state_q == S_RESPOND) ? gnt_onehot : '0;
   assign rsp_error     = (state_q == S_FLUSH && !flush2_q) ? gnt_onehot : '0;
   assign job_count     = job_q;
   assign timeout_count = tmo_q;

endmodule

// File: tb/tb_softmax_sched.sv
// tb_softmax_sched
// Self-checking bench for softmax_sched (NUM_REQ=4, TIMEOUT=16). It runs
// directed scenarios and randomised multi-requester traffic. The traffic is
// compared against an event-level model of the grant/launch/response timeline.
module tb_softmax_sched;

   localparam int NREQ    = 4;
   localparam int TMO     = 16;
   localparam int NEVER   = 1000;
   localparam int K_START = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERR   = 2;

   typedef struct {
      int cyc;
      int kind;
      int idx;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [1:0]  gnt_idx;
   logic        busy;
   logic        sm_start;
   logic        sm_done;
   logic        sm_rst;
   logic [3:0]  rsp_done;
   logic [3:0]  rsp_error;
   logic [15:0] job_count;
   logic [7:0]  timeout_count;

   int n_checks = 0;
   int n_fail   = 0;

   softmax_sched #(.NUM_REQ(NREQ), .TIMEOUT(TMO), .CNT_W(16)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .gnt_idx       (gnt_idx),
      .busy          (busy),
      .sm_start      (sm_start),
      .sm_done       (sm_done),
      .sm_rst        (sm_rst),
      .rsp_done      (rsp_done),
      .rsp_error     (rsp_error),
      .job_count     (job_count),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      req     = 4'b0000;
      sm_done = 1'b0;
      step();
      rst = 1'b0;
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int n;
      int idx;
      n   = 0;
      idx = -1;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            n++;
            idx = i;
         end
      end
      return (n == 1) ? idx : -1;
   endfunction

   task automatic test_reset();
      rst     = 1'b1;
      req     = 4'b0000;
      sm_done = 1'b0;
      step();
      n_checks++;
      if ({gnt_idx, busy, sm_start, sm_rst, rsp_done, rsp_error} !== 12'h000) begin
         $display("FAIL reset_outputs: got gnt=%0d busy=%b start=%b smrst=%b done=%b err=%b, expected all zero",
                  gnt_idx, busy, sm_start, sm_rst, rsp_done, rsp_error);
         n_fail++;
      end
      n_checks++;
      if (job_count !== 16'd0 || timeout_count !== 8'd0) begin
         $display("FAIL reset_counters: got job=%0d tmo=%0d, expected 0 0", job_count, timeout_count);
         n_fail++;
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_idle_busy: got %b, expected 0", busy);
         n_fail++;
      end
   endtask

   task automatic test_single();
      int bad;
      int lat;
      lat = 12;
      do_reset();
      req = 4'b0100;
      step();
      n_checks++;
      if (sm_start !== 1'b1 || gnt_idx !== 2'd2 || busy !== 1'b1) begin
         $display("FAIL single_launch: got start=%b gnt=%0d busy=%b, expected 1 2 1", sm_start, gnt_idx, busy);
         n_fail++;
      end
      bad = 0;
      for (int c = 2; c <= lat + 1; c++) begin
         step();
         if (sm_start !== 1'b0 || rsp_done !== 4'b0000 || busy !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         $display("FAIL single_wait: got %0d bad wait cycles, expected 0", bad);
         n_fail++;
      end
      sm_done = 1'b1;
      step();
      sm_done = 1'b0;
      n_checks++;
      if (rsp_done !== 4'b0100 || rsp_error !== 4'b0000) begin
         $display("FAIL single_rsp: got done=%b err=%b, expected 0100 0000", rsp_done, rsp_error);
         n_fail++;
      end
      step();
      req = 4'b0000;
      n_checks++;
      if (rsp_done !== 4'b0000 || busy !== 1'b0 || job_count !== 16'd1 || gnt_idx !== 2'd2) begin
         $display("FAIL single_after: got done=%b busy=%b job=%0d gnt=%0d, expected 0000 0 1 2",
                  rsp_done, busy, job_count, gnt_idx);
         n_fail++;
      end
      step();
      step();
      n_checks++;
      if (busy !== 1'b0 || sm_start !== 1'b0) begin
         $display("FAIL single_idle: got busy=%b start=%b, expected 0 0", busy, sm_start);
         n_fail++;
      end
   endtask

   task automatic test_timeout();
      int err_cyc;
      int err_cnt;
      int rst_bad;
      int start_c;
      int start_g;
      int done_seen;
      logic [3:0] err_val;
      err_cyc   = -1;
      err_cnt   = 0;
      rst_bad   = 0;
      start_c   = -1;
      start_g   = -1;
      done_seen = 0;
      err_val   = 4'b0000;
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= 22; c++) begin
         step();
         if (rsp_error !== 4'b0000) begin
            err_cnt++;
            if (err_cyc < 0) begin
               err_cyc = c;
               err_val = rsp_error;
            end
         end
         if (rsp_done !== 4'b0000) done_seen++;
         if (sm_rst !== ((c == 18) || (c == 19))) rst_bad++;
         if (c > 1 && sm_start === 1'b1) begin
            start_c = c;
            start_g = int'(gnt_idx);
         end
         if (c == 19) req = 4'b0010;
      end
      n_checks++;
      if (err_cyc != 18 || err_val !== 4'b0001 || err_cnt != 1) begin
         $display("FAIL timeout_err: got cyc=%0d val=%b count=%0d, expected 18 0001 1", err_cyc, err_val, err_cnt);
         n_fail++;
      end
      n_checks++;
      if (rst_bad != 0) begin
         $display("FAIL timeout_smrst: got %0d wrong cycles, expected 0", rst_bad);
         n_fail++;
      end
      n_checks++;
      if (timeout_count !== 8'd1 || done_seen != 0) begin
         $display("FAIL timeout_count: got tmo=%0d done_pulses=%0d, expected 1 0", timeout_count, done_seen);
         n_fail++;
      end
      n_checks++;
      if (start_c != 21 || start_g != 1) begin
         $display("FAIL timeout_next_grant: got cyc=%0d gnt=%0d, expected 21 1", start_c, start_g);
         n_fail++;
      end
   endtask

   task automatic test_collision_stray();
      int done_cyc;
      int done_cnt;
      int err_cnt;
      int late_bad;
      logic [3:0] done_val;
      done_cyc = -1;
      done_cnt = 0;
      err_cnt  = 0;
      late_bad = 0;
      done_val = 4'b0000;
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 26; c++) begin
         step();
         sm_done = (c == 17) || (c == 21);
         if (c == 19) req = 4'b0000;
         if (rsp_done !== 4'b0000) begin
            done_cnt++;
            done_cyc = c;
            done_val = rsp_done;
         end
         if (rsp_error !== 4'b0000) err_cnt++;
         if (c >= 22 && (busy !== 1'b0 || sm_start !== 1'b0)) late_bad++;
      end
      sm_done = 1'b0;
      n_checks++;
      if (done_cnt != 1 || done_cyc != 18 || done_val !== 4'b0001) begin
         $display("FAIL collision_done: got count=%0d cyc=%0d val=%b, expected 1 18 0001", done_cnt, done_cyc, done_val);
         n_fail++;
      end
      n_checks++;
      if (err_cnt != 0 || timeout_count !== 8'd0) begin
         $display("FAIL collision_no_err: got err_pulses=%0d tmo=%0d, expected 0 0", err_cnt, timeout_count);
         n_fail++;
      end
      n_checks++;
      if (late_bad != 0 || job_count !== 16'd1) begin
         $display("FAIL stray_done_idle: got bad=%0d job=%0d, expected 0 1", late_bad, job_count);
         n_fail++;
      end
   endtask

   task automatic test_withdrawal();
      int done_cyc;
      int s2_cyc;
      int s2_gnt;
      int early;
      logic [3:0] done_val;
      done_cyc = -1;
      s2_cyc   = -1;
      s2_gnt   = -1;
      early    = 0;
      done_val = 4'b0000;
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 3) req = 4'b0000;
         if (c == 4) req = 4'b1000;
         sm_done = (c == 8);
         if (rsp_done !== 4'b0000 && done_cyc < 0) begin
            done_cyc = c;
            done_val = rsp_done;
         end
         if (sm_start === 1'b1 && c > 1) begin
            if (c < 11) early++;
            if (s2_cyc < 0) begin
               s2_cyc = c;
               s2_gnt = int'(gnt_idx);
            end
         end
      end
      sm_done = 1'b0;
      n_checks++;
      if (done_cyc != 9 || done_val !== 4'b0010) begin
         $display("FAIL withdraw_done: got cyc=%0d val=%b, expected 9 0010", done_cyc, done_val);
         n_fail++;
      end
      n_checks++;
      if (early != 0 || s2_cyc != 11 || s2_gnt != 3) begin
         $display("FAIL withdraw_next: got early=%0d cyc=%0d gnt=%0d, expected 0 11 3", early, s2_cyc, s2_gnt);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_wait();
      int pulses;
      do_reset();
      req = 4'b0110;
      step();
      n_checks++;
      if (sm_start !== 1'b1 || gnt_idx !== 2'd1) begin
         $display("FAIL rstmid_first_grant: got start=%b gnt=%0d, expected 1 1", sm_start, gnt_idx);
         n_fail++;
      end
      step();
      step();
      step();
      rst = 1'b1;
      req = 4'b0111;
      #1;
      n_checks++;
      if ({gnt_idx, busy, sm_start, sm_rst, rsp_done, rsp_error} !== 12'h000) begin
         $display("FAIL rstmid_immediate: got gnt=%0d busy=%b start=%b smrst=%b done=%b err=%b, expected all zero",
                  gnt_idx, busy, sm_start, sm_rst, rsp_done, rsp_error);
         n_fail++;
      end
      step();
      pulses = (rsp_done !== 4'b0000 || rsp_error !== 4'b0000) ? 1 : 0;
      rst = 1'b0;
      step();
      n_checks++;
      if (pulses != 0 || sm_start !== 1'b1 || gnt_idx !== 2'd0 || job_count !== 16'd0) begin
         $display("FAIL rstmid_regrant: got pulses=%0d start=%b gnt=%0d job=%0d, expected 0 1 0 0",
                  pulses, sm_start, gnt_idx, job_count);
         n_fail++;
      end
      req = 4'b0000;
   endtask

   // Traffic from all requesters, each issuing n_per jobs and re-requesting
   // one cycle after every response. The expected timeline comes from an
   // event-level walk of round-robin arbitration and the documented latencies.
   task automatic test_traffic(input string name, input int n_per, input bit rnd);
      ev_t exp_q[$];
      ev_t obs_q[$];
      int  lat_q[$];
      int  fire_q[$];
      int  mrem[NREQ];
      int  brem[NREQ];
      bit  exp_rst[];
      int  t, p, last, last_t, g, s, lat, total, n_done, n_err, end_cyc;
      int  pidx, pcyc, js, oi, rst_bad, nmin;
      logic [3:0] rv;
      ev_t e;

      total = NREQ * n_per;
      for (int j = 0; j < total; j++) begin
         if (!rnd) begin
            lat = 5;
         end else begin
            case ($urandom_range(0, 9))
               0:       lat = TMO;
               1:       lat = NEVER;
               default: lat = int'($urandom_range(1, 8));
            endcase
         end
         lat_q.push_back(lat);
      end

      for (int r = 0; r < NREQ; r++) mrem[r] = n_per;
      t = 0; p = 0; last = -1; last_t = -10; n_done = 0; n_err = 0;
      for (int j = 0; j < total; ) begin
         g = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && mrem[(p + k) % NREQ] > 0 &&
                !(((p + k) % NREQ) == last && t == last_t + 1)) g = (p + k) % NREQ;
         end
         if (g < 0) begin
            t++;
         end else begin
            p   = (g + 1) % NREQ;
            s   = t + 1;
            lat = lat_q[j];
            j++;
            exp_q.push_back('{s, K_START, g});
            if (lat <= TMO) begin
               exp_q.push_back('{s + lat + 1, K_DONE, g});
               last_t = s + lat + 1;
               t      = s + lat + 2;
               n_done++;
            end else begin
               exp_q.push_back('{s + TMO + 1, K_ERR, g});
               last_t = s + TMO + 1;
               t      = s + TMO + 3;
               n_err++;
            end
            last = g;
            mrem[g]--;
         end
      end
      end_cyc = t + 4;
      exp_rst = new[end_cyc + 2];
      foreach (exp_q[k]) begin
         if (exp_q[k].kind == K_ERR) begin
            exp_rst[exp_q[k].cyc]     = 1'b1;
            exp_rst[exp_q[k].cyc + 1] = 1'b1;
         end
      end

      do_reset();
      for (int r = 0; r < NREQ; r++) brem[r] = n_per;
      pidx = -1; pcyc = -10; js = 0; rst_bad = 0;
      for (int c = 0; c < end_cyc; c++) begin
         if (c > 0) step();
         if (sm_start === 1'b1) begin
            obs_q.push_back('{c, K_START, int'(gnt_idx)});
            if (js < total) begin
               lat = lat_q[js];
               js++;
               fire_q.push_back((lat == NEVER) ? c + TMO + 1 : c + lat);
            end
         end
         if (rsp_done !== 4'b0000) begin
            oi = onehot_idx(rsp_done);
            obs_q.push_back('{c, K_DONE, oi});
            if (oi >= 0) begin
               brem[oi]--;
               pidx = oi;
               pcyc = c;
            end
         end
         if (rsp_error !== 4'b0000) begin
            oi = onehot_idx(rsp_error);
            obs_q.push_back('{c, K_ERR, oi});
            if (oi >= 0) begin
               brem[oi]--;
               pidx = oi;
               pcyc = c;
            end
         end
         if (sm_rst !== exp_rst[c]) rst_bad++;
         sm_done = 1'b0;
         if (fire_q.size() > 0 && fire_q[0] == c) begin
            sm_done = 1'b1;
            void'(fire_q.pop_front());
         end
         rv = 4'b0000;
         for (int r = 0; r < NREQ; r++) begin
            if (brem[r] > 0 && !(r == pidx && c == pcyc + 1)) rv = rv | (4'b0001 << r);
         end
         req = rv;
      end
      sm_done = 1'b0;
      req     = 4'b0000;

      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         $display("FAIL %s event_count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
         n_fail++;
      end
      nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < nmin; k++) begin
         n_checks++;
         if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].kind != exp_q[k].kind || obs_q[k].idx != exp_q[k].idx) begin
            $display("FAIL %s event_%0d: got cyc=%0d kind=%0d idx=%0d, expected cyc=%0d kind=%0d idx=%0d",
                     name, k, obs_q[k].cyc, obs_q[k].kind, obs_q[k].idx, exp_q[k].cyc, exp_q[k].kind, exp_q[k].idx);
            n_fail++;
         end
      end
      n_checks++;
      if (rst_bad != 0) begin
         $display("FAIL %s sm_rst_cycles: got %0d wrong cycles, expected 0", name, rst_bad);
         n_fail++;
      end
      n_checks++;
      if (job_count !== 16'(n_done) || timeout_count !== 8'(n_err)) begin
         $display("FAIL %s counters: got job=%0d tmo=%0d, expected %0d %0d", name, job_count, timeout_count, n_done, n_err);
         n_fail++;
      end
      if (!rnd) begin
         // Fixed 5-cycle jobs: strict 0,1,2,3 rotation, starts 8 cycles apart.
         js = 0;
         s  = -1;
         foreach (obs_q[k]) begin
            e = obs_q[k];
            if (e.kind == K_START) begin
               n_checks++;
               if (e.idx != js % NREQ || (s >= 0 && e.cyc - s != 8)) begin
                  $display("FAIL %s rr_order_%0d: got idx=%0d gap=%0d, expected idx=%0d gap=8",
                           name, js, e.idx, (s >= 0) ? e.cyc - s : 8, js % NREQ);
                  n_fail++;
               end
               s = e.cyc;
               js++;
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got simulation still running, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      rst     = 1'b1;
      req     = 4'b0000;
      sm_done = 1'b0;
      test_reset();
      test_single();
      test_traffic("round_robin", 2, 1'b0);
      test_timeout();
      test_collision_stray();
      test_withdrawal();
      test_reset_mid_wait();
      test_traffic("random_a", 6, 1'b1);
      test_traffic("random_b", 6, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
